pwm_capture: RTL and testbench

PWM duty-cycle receiver: samples a single-bit PWM waveform, measures high time and period between consecutive rising edges, and reports an 8-bit duty value in the same code space the LED brightness generator accepts. It sits on the return path of the LED/PWM subsystem so software can read back or loop-test the brightness actually driven on a pin. A timeout covers constant-level inputs: flat-low reports 0, flat-high reports 255.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_edge_sync.sv | 64 ++++++
 rtl/pwm_capture.sv | 155 +++++++++++++++
 tb/tb_pwm_capture.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM capture path.
//   state_t    - capture FSM states (IDLE, WAIT_EDGE, MEASURE)
//   DUTY_W     - width of the reported duty code
//   DUTY_MAX   - full-scale duty code (also the flat-high report)
//   level_duty - duty code reported for a constant-level input
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam int                DUTY_W   = 8;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

    // A waveform with no rising edge is either stuck low (duty 0) or
    // stuck high (full scale).
    function automatic logic [DUTY_W-1:0] level_duty(input logic level);
        return level ? DUTY_MAX : '0;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: brings pwm_in into the clk domain and detects rising edges.
// Build option: PWM_CAPTURE_SYNC_EN defined -> pwm_in passes through a 2-flop
// synchronizer (asynchronous input); undefined -> registered once.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset, clears every stage
//   pwm_in in   raw PWM waveform
//   level  out  sampled level, aligned with rise
//   rise   out  1 for one cycle per 0->1 transition of the sampled level
module pwm_edge_sync
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise
);

    logic s_p0;      // sampled signal s
    logic s_p1;      // s delayed one cycle (s_prev)
    logic rise_p1;   // edge flag, registered so it lines up with s_p1

`ifdef PWM_CAPTURE_SYNC_EN
    logic meta_p0;

    // Stage 0: two-flop synchronizer, pwm_in is asynchronous
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_p0 <= 1'b0;
            s_p0    <= 1'b0;
        end else begin
            meta_p0 <= pwm_in;
            s_p0    <= meta_p0;
        end
    end
`else
    // Stage 0: single input register, pwm_in is synchronous to clk
    always_ff @(posedge clk) begin
        if (reset) begin
            s_p0 <= 1'b0;
        end else begin
            s_p0 <= pwm_in;
        end
    end
`endif

    // Stage 1: previous sample and edge flag, both from the same s_p0 sample
    always_ff @(posedge clk) begin
        if (reset) begin
            s_p1    <= 1'b0;
            rise_p1 <= 1'b0;
        end else begin
            s_p1    <= s_p0;
            rise_p1 <= s_p0 & ~s_p1;
        end
    end

    // The level handed to the FSM is the sample that produced the edge, so
    // the rise cycle itself counts as a high cycle.
    assign level = s_p1;
    assign rise  = rise_p1;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: PWM duty-cycle receiver. Measures high time and period between
// consecutive rising edges of pwm_in and reports an 8-bit duty code (high
// count saturated at 255) plus the period. With no rising edge for TIMEOUT
// cycles a constant-level report is made: duty 0 (flat low) or 255 (flat
// high) with period 0.
// Build option: PWM_CAPTURE_SYNC_EN (see pwm_edge_sync) adds a synchronizer
// stage and one cycle of latency; measured values are unchanged.
// Parameters:
//   CNT_W    width of period/high counters and period_out
//   TIMEOUT  cycles without a rising edge before a constant-level report
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   enable     in   1 = measure, 0 = idle with counters cleared
//   pwm_in     in   PWM waveform
//   duty_out   out  last measured duty code
//   period_out out  last measured period (0 for a constant-level report)
//   duty_valid out  one-cycle pulse when duty_out/period_out update
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic [CNT_W-1:0]  period_out,
    output logic              duty_valid
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_FULL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DUTY_CAP = {{(CNT_W-DUTY_W){1'b0}}, DUTY_MAX};

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [CNT_W-1:0] cnt);
        return (cnt > DUTY_CAP) ? DUTY_MAX : cnt[DUTY_W-1:0];
    endfunction

    logic level;
    logic rise;

    pwm_edge_sync u_edge (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise)
    );

    state_t             state,      state_n;
    logic [CNT_W-1:0]   period_cnt, period_cnt_n;
    logic [CNT_W-1:0]   high_cnt,   high_cnt_n;
    logic [CNT_W-1:0]   to_cnt,     to_cnt_n;
    logic [DUTY_W-1:0]  duty_n;
    logic [CNT_W-1:0]   period_out_n;
    logic               valid_n;

    always_comb begin
        state_n      = state;
        period_cnt_n = period_cnt;
        high_cnt_n   = high_cnt;
        to_cnt_n     = to_cnt;
        duty_n       = duty_out;
        period_out_n = period_out;
        valid_n      = 1'b0;

        // Dropping enable discards any measurement in progress, no report.
        if (!enable) begin
            state_n      = IDLE;
            period_cnt_n = '0;
            high_cnt_n   = '0;
            to_cnt_n     = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n      = WAIT_EDGE;
                    period_cnt_n = '0;
                    high_cnt_n   = '0;
                    to_cnt_n     = '0;
                end

                WAIT_EDGE: begin
                    if (rise) begin
                        state_n      = MEASURE;
                        period_cnt_n = CNT_ONE;
                        high_cnt_n   = CNT_ONE;
                        to_cnt_n     = '0;
                    end else if (to_cnt == TO_LAST) begin
                        duty_n       = level_duty(level);
                        period_out_n = '0;
                        valid_n      = 1'b1;
                        to_cnt_n     = '0;
                    end else begin
                        to_cnt_n = to_cnt + CNT_ONE;
                    end
                end

                MEASURE: begin
                    // Rise is checked first so a period of exactly TIMEOUT
                    // is still reported as a real measurement.
                    if (rise) begin
                        duty_n       = sat_duty(high_cnt);
                        period_out_n = period_cnt;
                        valid_n      = 1'b1;
                        period_cnt_n = CNT_ONE;
                        high_cnt_n   = CNT_ONE;
                    end else if (period_cnt == TO_FULL) begin
                        duty_n       = level_duty(level);
                        period_out_n = '0;
                        valid_n      = 1'b1;
                        state_n      = WAIT_EDGE;
                        period_cnt_n = '0;
                        high_cnt_n   = '0;
                        to_cnt_n     = '0;
                    end else begin
                        period_cnt_n = period_cnt + CNT_ONE;
                        if (level) begin
                            high_cnt_n = high_cnt + CNT_ONE;
                        end
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // FSM/counter/output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            to_cnt     <= '0;
            duty_out   <= '0;
            period_out <= '0;
            duty_valid <= 1'b0;
        end else begin
            state      <= state_n;
            period_cnt <= period_cnt_n;
            high_cnt   <= high_cnt_n;
            to_cnt     <= to_cnt_n;
            duty_out   <= duty_n;
            period_out <= period_out_n;
            duty_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture.
// A PWM pattern (period, high) is replayed cycle by cycle; each window
// records the duty_valid pulses (count, first index, gaps, last values,
// edge-to-report latency) and these are compared to hand-derived values.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 512;
`ifdef PWM_CAPTURE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clk;
    logic             reset;
    logic             enable;
    logic             pwm_in;
    logic [7:0]       duty_out;
    logic [CNT_W-1:0] period_out;
    logic             duty_valid;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .period_out (period_out),
        .duty_valid (duty_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;
    int cyc;
    int gen_phase;
    int last_rise;

    // per-window pulse statistics
    int v_cnt;
    int v_first;
    int v_prev;
    int gap_min;
    int gap_max;
    int v_lat;
    int v_duty;
    int v_period;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive n cycles of a PWM with the given period/high count, continuing
    // from gen_phase; sample outputs 1 time unit after each rising clock edge.
    task automatic run(input int period, input int high, input int n);
        v_cnt   = 0;
        v_first = -1;
        v_prev  = -1;
        gap_min = 1000000;
        gap_max = 0;
        v_lat   = -1;
        for (int i = 0; i < n; i++) begin
            logic nv;
            nv = (gen_phase < high);
            if (nv && !pwm_in) last_rise = cyc;
            pwm_in = nv;
            gen_phase++;
            if (gen_phase >= period) gen_phase = 0;
            @(posedge clk);
            #1;
            cyc++;
            if (duty_valid) begin
                if (v_cnt == 0) begin
                    v_first = i;
                end else begin
                    if (i - v_prev < gap_min) gap_min = i - v_prev;
                    if (i - v_prev > gap_max) gap_max = i - v_prev;
                end
                v_prev   = i;
                v_cnt++;
                v_duty   = int'(duty_out);
                v_period = int'(period_out);
                v_lat    = (cyc - 1) - last_rise;
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        cyc       = 0;
        gen_phase = 0;
        last_rise = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        pwm_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("reset_duty",   int'(duty_out),   0);
        check("reset_period", int'(period_out), 0);
        check("reset_valid",  int'(duty_valid), 0);

        reset = 1'b0;
        run(1, 0, 4);
        check("idle_no_valid", v_cnt, 0);

        // B=64 on an 8-bit counter: first report after the second edge
        enable    = 1'b1;
        gen_phase = 0;
        run(256, 64, 1280);
        check("b64_count",   v_cnt,    4);
        check("b64_first",   v_first,  256 + LAT);
        check("b64_gap_min", gap_min,  256);
        check("b64_gap_max", gap_max,  256);
        check("b64_duty",    v_duty,   64);
        check("b64_period",  v_period, 256);
        check("b64_latency", v_lat,    LAT);

        run(256, 255, 1024);
        check("b255_count",  v_cnt,    4);
        check("b255_duty",   v_duty,   255);
        check("b255_period", v_period, 256);

        run(256, 1, 1024);
        check("b1_duty",   v_duty,   1);
        check("b1_period", v_period, 256);

        // Period 300, high 280: duty saturates
        gen_phase = 0;
        run(300, 280, 1200);
        check("sat_duty",    v_duty,   255);
        check("sat_period",  v_period, 300);
        check("sat_gap_min", gap_min,  300);
        check("sat_gap_max", gap_max,  300);

        // Flat low: MEASURE timeout, then WAIT_EDGE timeout every 512
        run(1, 0, 1500);
        check("low_count",   v_cnt,    3);
        check("low_first",   v_first,  212 + LAT);
        check("low_gap",     gap_min,  512);
        check("low_gap_max", gap_max,  512);
        check("low_duty",    v_duty,   0);
        check("low_period",  v_period, 0);

        // Flat high: one rise, then timeouts report full scale
        run(1, 1, 1600);
        check("high_count",  v_cnt,    3);
        check("high_first",  v_first,  512 + LAT);
        check("high_gap",    gap_min,  512);
        check("high_duty",   v_duty,   255);
        check("high_period", v_period, 0);

        // Reset mid-MEASURE
        gen_phase = 0;
        run(256, 64, 700);
        check("prerst_duty", v_duty, 64);
        reset = 1'b1;
        run(256, 64, 1);
        check("rst_mid_duty",   int'(duty_out),   0);
        check("rst_mid_period", int'(period_out), 0);
        check("rst_mid_valid",  int'(duty_valid), 0);
        reset     = 1'b0;
        gen_phase = 0;
        run(256, 64, 600);
        check("postrst_count", v_cnt,   2);
        check("postrst_first", v_first, 256 + LAT);
        check("postrst_duty",  v_duty,  64);

        // Enable dropped mid-period, then restored
        enable = 1'b0;
        run(256, 64, 100);
        check("dis_count",       v_cnt,            0);
        check("dis_hold_duty",   int'(duty_out),   64);
        check("dis_hold_period", int'(period_out), 256);
        enable = 1'b1;
        run(256, 64, 400);
        check("reen_count",  v_cnt,    1);
        check("reen_first",  v_first,  324 + LAT);
        check("reen_duty",   v_duty,   64);
        check("reen_period", v_period, 256);

        // Period exactly TIMEOUT: rise and timeout coincide, rise wins
        gen_phase = 0;
        run(512, 100, 1536);
        check("tie_count",  v_cnt,    3);
        check("tie_gap",    gap_min,  512);
        check("tie_duty",   v_duty,   100);
        check("tie_period", v_period, 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
